// File: rtl/qam_pkg.sv
// Shared definitions for the QAM symbol datapath blocks.
package qam_pkg;

  // Serializer control state; the encoding is shared with other QAM blocks.
  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } ser_state_e;

endpackage : qam_pkg

// File: rtl/symbol_serializer.sv
// Parallel-to-serial converter for QAM symbol words. A word is shifted out one
// bit per consumed cycle, with a one-word hold register so that back-to-back
// words stream without a gap bit.
module symbol_serializer
  import qam_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  input  logic             flush,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             sym_start,
  output logic             sym_last,
  output logic             busy
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             accept;
  logic             bypass;
  logic             cnt_last;
  logic [WIDTH-1:0] sreg_shifted;

  // Handshake: a held word blocks new loads, and flush refuses them outright.
  always_comb begin
    load_ready = !hold_full_q && !flush;
    accept     = load_valid && load_ready;
  end

  // Move the register one position toward whichever end feeds serial_out.
  always_comb begin
    sreg_shifted = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
    cnt_last     = (cnt_q == CntLast);
  end

  // Next-state logic for FSM, shift register, counter and hold register.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bypass      = 1'b0;

    if (flush) begin
      state_d     = StIdle;
      sreg_d      = '0;
      cnt_d       = '0;
      hold_d      = '0;
      hold_full_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            sreg_d  = parallel_in;
            cnt_d   = '0;
            state_d = StShift;
          end
        end

        StShift: begin
          if (shift_en) begin
            if (!cnt_last) begin
              sreg_d = sreg_shifted;
              cnt_d  = cnt_q + CntW'(1);
            end else if (hold_full_q) begin
              // Held word is older than anything on parallel_in, so it goes first.
              sreg_d      = hold_q;
              cnt_d       = '0;
              hold_full_d = 1'b0;
            end else if (accept) begin
              sreg_d = parallel_in;
              cnt_d  = '0;
              bypass = 1'b1;
            end else begin
              state_d = StIdle;
              sreg_d  = '0;
              cnt_d   = '0;
            end
          end
          if (accept && !bypass) begin
            hold_d      = parallel_in;
            hold_full_d = 1'b1;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

  // Output decode; everything is forced low outside StShift.
  always_comb begin
    serial_valid = (state_q == StShift);
    serial_out   = 1'b0;
    if (serial_valid) begin
      serial_out = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
    end
    sym_start = serial_valid && (cnt_q == '0);
    sym_last  = serial_valid && cnt_last;
    busy      = serial_valid || hold_full_q;
  end

endmodule : symbol_serializer

// File: tb/tb_symbol_serializer.sv
// Bench for symbol_serializer: LSB-first and MSB-first instances share stimulus
// and are checked every cycle against a word-queue reference model.
module tb_symbol_serializer;

  localparam int W = 4;

  logic         clock;
  logic         clear_n;
  logic [W-1:0] parallel_in;
  logic         load_valid;
  logic         shift_en;
  logic         flush;

  logic ready_l, out_l, valid_l, start_l, last_l, busy_l;
  logic ready_m, out_m, valid_m, start_m, last_m, busy_m;

  int n_cmp;
  int n_fail;

  // Reference model: current word with bit index, plus queue of accepted words.
  logic [W-1:0] m_cur;
  int           m_idx;
  bit           m_act;
  logic [W-1:0] m_pend[$];

  // Serial bits consumed by the sink, in arrival order (newest in bit 0).
  logic [15:0] cap_l, cap_m;

  symbol_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clock       (clock),
    .clear_n     (clear_n),
    .parallel_in (parallel_in),
    .load_valid  (load_valid),
    .load_ready  (ready_l),
    .shift_en    (shift_en),
    .flush       (flush),
    .serial_out  (out_l),
    .serial_valid(valid_l),
    .sym_start   (start_l),
    .sym_last    (last_l),
    .busy        (busy_l)
  );

  symbol_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clock       (clock),
    .clear_n     (clear_n),
    .parallel_in (parallel_in),
    .load_valid  (load_valid),
    .load_ready  (ready_m),
    .shift_en    (shift_en),
    .flush       (flush),
    .serial_out  (out_m),
    .serial_valid(valid_m),
    .sym_start   (start_m),
    .sym_last    (last_m),
    .busy        (busy_m)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_clear();
    m_pend.delete();
    m_act = 1'b0;
    m_idx = 0;
    m_cur = '0;
  endtask

  // Outputs as {load_ready, serial_out, serial_valid, sym_start, sym_last, busy}.
  task automatic check_outputs(input string tag);
    logic [5:0] exp_l, exp_m, got_l, got_m;
    logic       bl, bm, rdy, bsy;
    bl    = m_act ? m_cur[m_idx] : 1'b0;
    bm    = m_act ? m_cur[W-1-m_idx] : 1'b0;
    rdy   = (m_pend.size() == 0) && !flush;
    bsy   = m_act || (m_pend.size() != 0);
    exp_l = {rdy, bl, m_act, m_act && (m_idx == 0), m_act && (m_idx == W - 1), bsy};
    exp_m = {rdy, bm, m_act, m_act && (m_idx == 0), m_act && (m_idx == W - 1), bsy};
    got_l = {ready_l, out_l, valid_l, start_l, last_l, busy_l};
    got_m = {ready_m, out_m, valid_m, start_m, last_m, busy_m};
    n_cmp++;
    assert (got_l === exp_l) else begin
      n_fail++;
      $error("FAIL %s lsb_first rdy/out/vld/sta/lst/bsy: got %b want %b", tag, got_l, exp_l);
    end
    n_cmp++;
    assert (got_m === exp_m) else begin
      n_fail++;
      $error("FAIL %s msb_first rdy/out/vld/sta/lst/bsy: got %b want %b", tag, got_m, exp_m);
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance model and clock.
  task automatic step(input string tag, input logic lv, input logic [W-1:0] d,
                      input logic sh, input logic fl);
    load_valid  = lv;
    parallel_in = d;
    shift_en    = sh;
    flush       = fl;
    #3;
    check_outputs(tag);
    if (sh && valid_l) cap_l = {cap_l[14:0], out_l};
    if (sh && valid_m) cap_m = {cap_m[14:0], out_m};
    if (fl) begin
      model_clear();
    end else begin
      if (lv && (m_pend.size() == 0)) m_pend.push_back(d);
      if (m_act && sh) begin
        m_idx++;
        if (m_idx == W) m_act = 1'b0;
      end
      if (!m_act && (m_pend.size() > 0)) begin
        m_cur = m_pend.pop_front();
        m_idx = 0;
        m_act = 1'b1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Asynchronous clear pulse spanning one rising edge.
  task automatic reset_pulse(input string tag);
    flush      = 1'b0;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    clear_n    = 1'b0;
    model_clear();
    #2;
    check_outputs(tag);
    @(posedge clock);
    #1;
    check_outputs(tag);
    clear_n = 1'b1;
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    cap_l       = '0;
    cap_m       = '0;
    clear_n     = 1'b0;
    load_valid  = 1'b0;
    parallel_in = '0;
    shift_en    = 1'b0;
    flush       = 1'b0;
    model_clear();
    #1;
    check_outputs("reset");
    @(posedge clock);
    @(posedge clock);
    #1;
    clear_n = 1'b1;
    step("idle", 1'b0, 4'h0, 1'b1, 1'b0);

    // Single word 1011, continuous consumption.
    cap_l = '0;
    cap_m = '0;
    step("single_load", 1'b1, 4'b1011, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("single_shift", 1'b0, 4'h0, 1'b1, 1'b0);
    n_cmp++;
    assert (cap_l[3:0] === 4'b1101) else begin
      n_fail++;
      $error("FAIL single_bits_lsb: got %b want %b", cap_l[3:0], 4'b1101);
    end
    n_cmp++;
    assert (cap_m[3:0] === 4'b1011) else begin
      n_fail++;
      $error("FAIL single_bits_msb: got %b want %b", cap_m[3:0], 4'b1011);
    end

    // Back-to-back A then 5 with no gap bit.
    cap_l = '0;
    step("b2b_load_a", 1'b1, 4'hA, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("b2b_shift", 1'b0, 4'h0, 1'b1, 1'b0);
    step("b2b_load_5", 1'b1, 4'h5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("b2b_shift", 1'b0, 4'h0, 1'b1, 1'b0);
    n_cmp++;
    assert (cap_l[7:0] === 8'b0101_1010) else begin
      n_fail++;
      $error("FAIL b2b_bits: got %b want %b", cap_l[7:0], 8'b0101_1010);
    end

    // Stall at bit 2 with a second word pending in the hold register.
    cap_l = '0;
    step("stall_load_a", 1'b1, 4'hA, 1'b1, 1'b0);
    step("stall_bit1", 1'b0, 4'h0, 1'b1, 1'b0);
    step("stall_hold", 1'b1, 4'h5, 1'b0, 1'b0);
    step("stall_hold", 1'b1, 4'h3, 1'b0, 1'b0);
    step("stall_hold", 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("stall_drain", 1'b0, 4'h0, 1'b1, 1'b0);
    n_cmp++;
    assert (cap_l[7:0] === 8'b0101_1010) else begin
      n_fail++;
      $error("FAIL stall_bits: got %b want %b", cap_l[7:0], 8'b0101_1010);
    end

    // Flush at bit 3 while the hold register is full.
    step("flush_load_a", 1'b1, 4'hA, 1'b1, 1'b0);
    step("flush_load_5", 1'b1, 4'h5, 1'b1, 1'b0);
    step("flush_bit2", 1'b0, 4'h0, 1'b1, 1'b0);
    step("flush_bit3", 1'b1, 4'hF, 1'b1, 1'b1);
    load_valid = 1'b0;
    flush      = 1'b0;
    #1;
    n_cmp++;
    assert ({valid_l, busy_l, ready_l} === 3'b001) else begin
      n_fail++;
      $error("FAIL flush_after vld/bsy/rdy: got %b want %b", {valid_l, busy_l, ready_l}, 3'b001);
    end
    step("flush_idle", 1'b0, 4'h0, 1'b1, 1'b0);

    // Clear mid-symbol with a held word, then a fresh word.
    step("clr_load_a", 1'b1, 4'hA, 1'b1, 1'b0);
    step("clr_load_c", 1'b1, 4'hC, 1'b0, 1'b0);
    reset_pulse("clr_pulse");
    cap_l = '0;
    cap_m = '0;
    step("clr_idle", 1'b0, 4'h0, 1'b1, 1'b0);
    step("clr_reload", 1'b1, 4'b0110, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("clr_shift", 1'b0, 4'h0, 1'b1, 1'b0);
    n_cmp++;
    assert (cap_l[7:0] === 8'b0000_0110) else begin
      n_fail++;
      $error("FAIL clr_bits_lsb: got %b want %b", cap_l[7:0], 8'b0000_0110);
    end
    n_cmp++;
    assert (cap_m[7:0] === 8'b0000_0110) else begin
      n_fail++;
      $error("FAIL clr_bits_msb: got %b want %b", cap_m[7:0], 8'b0000_0110);
    end

    // Randomised traffic with occasional flush and one clear pulse.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_pulse("rand_clr");
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_symbol_serializer
